// File: rtl/fp_result_fifo_if.sv
// Handshake bundle between the FP multiplier, the result FIFO and its consumer.
// The slave modport is the FIFO's view; the master modport is the producer/consumer view.
interface fp_result_fifo_if #(
    parameter int width = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [width-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [width-1:0] out_data;
    logic [3:0]       out_class;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_class
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_class
    );
endinterface

// File: rtl/fp_result_fifo.sv
// Register FIFO for multiplier results; each entry is tagged {nan, inf, zero, sub} at push.
// Optional NaN/Inf push counters are enabled by defining FP_RESULT_FIFO_STATS_EN.
module fp_result_fifo #(
    parameter int width = 32,
    parameter int EXP_W = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_flush,
    fp_result_fifo_if.slave          bus,
    output logic [$clog2(DEPTH):0]   o_count
`ifdef FP_RESULT_FIFO_STATS_EN
    ,
    output logic [7:0]               o_nan_cnt,
    output logic [7:0]               o_inf_cnt
`endif
);
    localparam int MAN_W = width - 1 - EXP_W;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    function automatic logic [3:0] fp_classify(input logic [width-1:0] d);
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] m;
        logic             e_ones;
        logic             e_zero;
        logic             m_zero;
        e      = d[width-2 -: EXP_W];
        m      = d[MAN_W-1:0];
        e_ones = &e;
        e_zero = ~|e;
        m_zero = ~|m;
        return {e_ones & ~m_zero, e_ones & m_zero, e_zero & m_zero, e_zero & ~m_zero};
    endfunction

    logic [width-1:0] r_mem [DEPTH];
    logic [3:0]       r_cls [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;
    logic [3:0]       w_in_class;

    // in_ready ignores out_ready so a full FIFO never accepts while popping
    assign bus.in_ready  = (r_count < CNT_FULL);
    assign bus.out_valid = (r_count != {CW{1'b0}});
    assign bus.out_data  = r_mem[r_rd_ptr];
    assign bus.out_class = r_cls[r_rd_ptr];
    assign o_count       = r_count;
    assign w_push        = bus.in_valid & bus.in_ready;
    assign w_pop         = bus.out_valid & bus.out_ready;
    assign w_in_class    = fp_classify(bus.in_data);

    // Storage, pointers and occupancy; flush clears bookkeeping but leaves storage intact
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {width{1'b0}};
                r_cls[i] <= 4'b0000;
            end
        end else if (i_flush) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= bus.in_data;
                r_cls[r_wr_ptr] <= w_in_class;
                r_wr_ptr        <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef FP_RESULT_FIFO_STATS_EN
    logic [7:0] r_nan_cnt;
    logic [7:0] r_inf_cnt;

    assign o_nan_cnt = r_nan_cnt;
    assign o_inf_cnt = r_inf_cnt;

    // Saturating counts of NaN / Inf results accepted into the FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nan_cnt <= 8'h00;
            r_inf_cnt <= 8'h00;
        end else if (i_flush) begin
            r_nan_cnt <= 8'h00;
            r_inf_cnt <= 8'h00;
        end else begin
            if (w_push && w_in_class[3] && (r_nan_cnt != 8'hFF)) begin
                r_nan_cnt <= r_nan_cnt + 8'h01;
            end
            if (w_push && w_in_class[2] && (r_inf_cnt != 8'hFF)) begin
                r_inf_cnt <= r_inf_cnt + 8'h01;
            end
        end
    end
`endif
endmodule

// File: doc/fp_result_fifo.md
Name: fp_result_fifo

Overview:
- Buffering stage directly downstream of the combinational floating-point multiplier (`mult`).
- Accepts IEEE-754 results on a valid/ready handshake and stores them in a small register FIFO.
- Tags each entry with a class code at write time, so the consumer (ALU writeback / result register) gets data plus exception flags without recomputing them.
- Decouples the multiplier's combinational output from a back-pressuring consumer.

Parameters:
- width, 32, word width of stored floating-point value (matches `mult`).
- EXP_W, 8, exponent field width; mantissa width MAN_W = width-1-EXP_W (local).
- DEPTH, 4, number of entries; power of two, >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of all entries.
- in_valid  input  1  producer has a result on in_data.
- in_ready  output  1  FIFO can accept this cycle.
- in_data  input  width  result word from `mult`.
- out_valid  output  1  head entry valid.
- out_ready  input  1  consumer takes head entry this cycle.
- out_data  output  width  head entry value.
- out_class  output  4  head entry class {nan, inf, zero, sub}.
- count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (rst_n=0, async): wr_ptr=0, rd_ptr=0, count=0, all memory and class storage cleared to 0. Resulting outputs: out_valid=0, in_ready=1, out_data=0, out_class=0. Reset mid-transfer discards all entries.
- Handshake rules:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_ready = (count < DEPTH); it does not depend on out_ready, so a full FIFO refuses a push even while popping.
  - out_valid = (count != 0).
- Data path:
  - out_data and out_class are read combinationally from the entry at rd_ptr.
  - Latency: a word pushed at edge N into an empty FIFO appears with out_valid=1 after edge N (one cycle).
- Pointer and count update:
  - Pointers wrap modulo DEPTH.
  - push only: count+1. pop only: count-1. Push and pop together: count unchanged, both pointers advance.
  - Push when empty: no pop is possible that cycle because out_valid=0.
  - Holding in_valid with in_ready=0 has no effect; the producer must hold data.
- Classification, computed on in_data at push time (e = exponent field, m = mantissa field):
  - nan: e all ones and m != 0.
  - inf: e all ones and m == 0.
  - zero: e == 0 and m == 0.
  - sub: e == 0 and m != 0.
  - Normal numbers: class = 0000.
  - Sign is not encoded in the class; it is taken from out_data[width-1].
- flush=1 at a clock edge: pointers and count go to 0. Flush beats a simultaneous push or pop; the pushed word is dropped. Memory contents are not cleared.
- No overflow or underflow is possible by construction. The bench asserts count never exceeds DEPTH.

Optional Feature:
- Macro: FP_RESULT_FIFO_STATS_EN.
- When defined, adds outputs nan_cnt[7:0] and inf_cnt[7:0].
  - Each increments on a push whose class is nan / inf respectively.
  - Counters saturate at 8'hFF.
  - Cleared by rst_n and by flush.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Push 0x40100000 into empty FIFO, out_ready=0 -> next cycle out_valid=1, out_data=0x40100000, out_class=0000, count=1.
- Push 0x7FC00000, 0xFF800000, 0x80000000, 0x00000001 back-to-back, then pop all with out_ready=1 -> class sequence 1000, 0100, 0010, 0001, in order. out_data[31]=1 for 0xFF800000 and 0x80000000.
- Push 5 words with out_ready=0 -> in_ready drops after the 4th, count=4, 5th held off. After one pop the 5th is accepted and FIFO order is preserved.
- At count=2, push and pop in the same cycle for 6 cycles -> count stays 2, pointers wrap past DEPTH, data order intact.
- At count=3, flush=1 together with in_valid=1 -> count=0, out_valid=0 next cycle, pushed word lost. With FP_RESULT_FIFO_STATS_EN after pushing 2 NaNs: nan_cnt 2 -> 0.
- Assert rst_n=0 asynchronously mid-burst at count=2 -> out_valid=0, count=0, out_data=0 immediately, without waiting for a clock edge.
